// File: rtl/pixel_cluster_pkg.sv
// Shared types and constants for the pixel-cluster frame controller.
// Optional IRQ support is selected with PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN.
package pixel_cluster_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_DRAIN,
    ST_CAPTURE,
    ST_CLEAR
  } state_t;

  localparam int unsigned AVS_ADDR_W = 5;
  localparam int unsigned AVS_DATA_W = 32;
  localparam int unsigned FCNT_W     = 16;

  // Register word addresses
  localparam logic [AVS_ADDR_W-1:0] CTRL     = 5'd0;
  localparam logic [AVS_ADDR_W-1:0] STATUS   = 5'd1;
  localparam logic [AVS_ADDR_W-1:0] RGB_CMP  = 5'd2;
  localparam logic [AVS_ADDR_W-1:0] CMP_CFG  = 5'd3;
  localparam logic [AVS_ADDR_W-1:0] RANGE    = 5'd4;
  localparam logic [AVS_ADDR_W-1:0] XY_BASE  = 5'd8;
  localparam logic [AVS_ADDR_W-1:0] CNT_BASE = 5'd16;

  // CTRL bits
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_STOP_BIT  = 2;
  localparam int unsigned CTRL_IE_BIT    = 3;

  // STATUS bits
  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_ERR_BIT  = 2;
  localparam int unsigned STAT_FCNT_LSB = 16;

  // CMP_CFG: compare enables at bit 0, less-than directions at this offset
  localparam int unsigned CMP_LT_LSB = 4;

endpackage

// File: rtl/pixel_cluster_frame_ctrl_if.sv
// Avalon-MM register bus of the pixel-cluster frame controller.
interface pixel_cluster_frame_ctrl_if;
  import pixel_cluster_pkg::*;

  logic [AVS_ADDR_W-1:0] avs_address;
  logic                  avs_read;
  logic                  avs_write;
  logic [AVS_DATA_W-1:0] avs_writedata;
  logic [AVS_DATA_W-1:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pixel_cluster_frame_ctrl_regs.sv
// Register front end: address decode, shadow config, sticky status, readback.
// CTRL b3 (interrupt enable) exists only with PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN.
module pixel_cluster_frame_ctrl_regs
  import pixel_cluster_pkg::*;
#(
  parameter int unsigned N_CLUSTERS   = 4,
  parameter int unsigned X_Y_BITS     = 16,
  parameter int unsigned COUNTER_BITS = 16,
  parameter int unsigned COLOR_BITS   = 8,
  parameter int unsigned N_COLORS     = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  pixel_cluster_frame_ctrl_if.slave          avs,
  input  logic                               busy_i,
  input  logic                               capture_i,
  input  logic                               frame_err_i,
  input  logic [FCNT_W-1:0]                  frame_count_i,
  input  logic [N_CLUSTERS*X_Y_BITS-1:0]     x_res_i,
  input  logic [N_CLUSTERS*X_Y_BITS-1:0]     y_res_i,
  input  logic [N_CLUSTERS*COUNTER_BITS-1:0] cnt_res_i,
  output logic                               start_c,
  output logic                               stop_c,
  output logic                               continuous_o,
  output logic [N_COLORS*COLOR_BITS-1:0]     rgb_cmp_o,
  output logic [N_COLORS-1:0]                compare_o,
  output logic [N_COLORS-1:0]                less_than_o,
  output logic [X_Y_BITS-1:0]                range_o,
  output logic                               done_o
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  ,
  output logic                               ie_o
`endif
);

  localparam int unsigned RGB_W = N_COLORS * COLOR_BITS;

  logic                  wr_c;
  logic [AVS_DATA_W-1:0] wdata;
  logic [AVS_DATA_W-1:0] rd_data_c;
  logic [AVS_DATA_W-1:0] readdata_q;
  logic                  continuous_q;
  logic [RGB_W-1:0]      rgb_q;
  logic [N_COLORS-1:0]   compare_q;
  logic [N_COLORS-1:0]   less_than_q;
  logic [X_Y_BITS-1:0]   range_q;
  logic                  done_q;
  logic                  err_q;
  logic                  unused_wdata;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  logic                  ie_q;
`endif

  assign wr_c  = avs.avs_write;
  assign wdata = avs.avs_writedata;
  assign unused_wdata = ^wdata;

  // START/STOP are write-one strobes consumed by the sequencer in the write cycle
  assign start_c = wr_c && (avs.avs_address == CTRL) && wdata[CTRL_START_BIT];
  assign stop_c  = wr_c && (avs.avs_address == CTRL) && wdata[CTRL_STOP_BIT];

  // Register writes, sticky status flags and registered readback
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      continuous_q <= 1'b0;
      rgb_q        <= '0;
      compare_q    <= '0;
      less_than_q  <= '0;
      range_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      readdata_q   <= '0;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
      ie_q         <= 1'b0;
`endif
    end else begin
      if (wr_c) begin
        case (avs.avs_address)
          CTRL: begin
            continuous_q <= wdata[CTRL_CONT_BIT];
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
            ie_q         <= wdata[CTRL_IE_BIT];
`endif
          end
          RGB_CMP: rgb_q       <= wdata[RGB_W-1:0];
          CMP_CFG: begin
            compare_q   <= wdata[N_COLORS-1:0];
            less_than_q <= wdata[CMP_LT_LSB +: N_COLORS];
          end
          RANGE:   range_q     <= wdata[X_Y_BITS-1:0];
          default: ;
        endcase
      end
      // Hardware set has priority over a simultaneous write-one-to-clear
      if (capture_i) begin
        done_q <= 1'b1;
      end else if (wr_c && (avs.avs_address == STATUS) && wdata[STAT_DONE_BIT]) begin
        done_q <= 1'b0;
      end
      if (frame_err_i) begin
        err_q <= 1'b1;
      end else if (wr_c && (avs.avs_address == STATUS) && wdata[STAT_ERR_BIT]) begin
        err_q <= 1'b0;
      end
      if (avs.avs_read) begin
        readdata_q <= rd_data_c;
      end
    end
  end

  // Readback mux; unmapped addresses read as zero
  always_comb begin
    rd_data_c = '0;
    case (avs.avs_address)
      CTRL: begin
        rd_data_c[CTRL_CONT_BIT] = continuous_q;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
        rd_data_c[CTRL_IE_BIT]   = ie_q;
`endif
      end
      STATUS: begin
        rd_data_c[STAT_BUSY_BIT]            = busy_i;
        rd_data_c[STAT_DONE_BIT]            = done_q;
        rd_data_c[STAT_ERR_BIT]             = err_q;
        rd_data_c[STAT_FCNT_LSB +: FCNT_W]  = frame_count_i;
      end
      RGB_CMP: rd_data_c = AVS_DATA_W'(rgb_q);
      CMP_CFG: begin
        rd_data_c[N_COLORS-1:0]            = compare_q;
        rd_data_c[CMP_LT_LSB +: N_COLORS]  = less_than_q;
      end
      RANGE:   rd_data_c = AVS_DATA_W'(range_q);
      default: ;
    endcase
    for (int unsigned i = 0; i < N_CLUSTERS; i++) begin
      if (avs.avs_address == AVS_ADDR_W'(XY_BASE + i)) begin
        rd_data_c = AVS_DATA_W'({y_res_i[i*X_Y_BITS +: X_Y_BITS],
                                 x_res_i[i*X_Y_BITS +: X_Y_BITS]});
      end
      if (avs.avs_address == AVS_ADDR_W'(CNT_BASE + i)) begin
        rd_data_c = AVS_DATA_W'(cnt_res_i[i*COUNTER_BITS +: COUNTER_BITS]);
      end
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign continuous_o     = continuous_q;
  assign rgb_cmp_o        = rgb_q;
  assign compare_o        = compare_q;
  assign less_than_o      = less_than_q;
  assign range_o          = range_q;
  assign done_o           = done_q;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  assign ie_o             = ie_q;
`endif

endmodule

// File: rtl/pixel_cluster_frame_ctrl.sv
// Per-frame sequencer for the pixel-cluster datapath: latches config at SOP,
// gates the stream to whole frames, drains, captures results, clears clusterer.
// Define PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN to add the irq output (done & ie).
module pixel_cluster_frame_ctrl
  import pixel_cluster_pkg::*;
#(
  parameter int unsigned N_CLUSTERS   = 4,
  parameter int unsigned X_Y_BITS     = 16,
  parameter int unsigned COUNTER_BITS = 16,
  parameter int unsigned COLOR_BITS   = 8,
  parameter int unsigned N_COLORS     = 3,
  parameter int unsigned DRAIN_CYCLES = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  pixel_cluster_frame_ctrl_if.slave          avs,
  input  logic                               st_valid,
  input  logic                               st_ready,
  input  logic                               st_startofpacket,
  input  logic                               st_endofpacket,
  output logic [N_COLORS*COLOR_BITS-1:0]     rgb_cmp,
  output logic [N_COLORS-1:0]                compare,
  output logic [N_COLORS-1:0]                less_than,
  output logic [X_Y_BITS-1:0]                range,
  output logic                               stream_enable,
  output logic                               cluster_clear,
  input  logic [N_CLUSTERS*X_Y_BITS-1:0]     X_clusters,
  input  logic [N_CLUSTERS*X_Y_BITS-1:0]     Y_clusters,
  input  logic [N_CLUSTERS*COUNTER_BITS-1:0] cluster_counters
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  ,
  output logic                               irq
`endif
);

  localparam int unsigned RGB_W   = N_COLORS * COLOR_BITS;
  // Counter holds DRAIN_CYCLES-1 down to 0, so DRAIN lasts DRAIN_CYCLES cycles
  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                            state_q;
  logic [DRAIN_W-1:0]                drain_q;
  logic                              stop_pend_q;
  logic                              clear_q;
  logic [RGB_W-1:0]                  act_rgb_q;
  logic [N_COLORS-1:0]               act_cmp_q;
  logic [N_COLORS-1:0]               act_lt_q;
  logic [X_Y_BITS-1:0]               act_range_q;
  logic [N_CLUSTERS*X_Y_BITS-1:0]    x_res_q;
  logic [N_CLUSTERS*X_Y_BITS-1:0]    y_res_q;
  logic [N_CLUSTERS*COUNTER_BITS-1:0] cnt_res_q;
  logic [FCNT_W-1:0]                 fcnt_q;

  logic              beat_c, sop_c, eop_c;
  logic              start_c, stop_c, continuous;
  logic              done;
  logic              err_c, capture_c, busy_c;
  logic [RGB_W-1:0]  sh_rgb;
  logic [N_COLORS-1:0] sh_cmp, sh_lt;
  logic [X_Y_BITS-1:0] sh_range;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  logic              ie;
`endif

  assign beat_c    = st_valid & st_ready;
  assign sop_c     = beat_c & st_startofpacket;
  assign eop_c     = beat_c & st_endofpacket;
  assign err_c     = (state_q == ST_RUN) & sop_c;
  assign capture_c = (state_q == ST_CAPTURE);
  assign busy_c    = (state_q != ST_IDLE);

  pixel_cluster_frame_ctrl_regs #(
    .N_CLUSTERS   (N_CLUSTERS),
    .X_Y_BITS     (X_Y_BITS),
    .COUNTER_BITS (COUNTER_BITS),
    .COLOR_BITS   (COLOR_BITS),
    .N_COLORS     (N_COLORS)
  ) u_regs (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs           (avs),
    .busy_i        (busy_c),
    .capture_i     (capture_c),
    .frame_err_i   (err_c),
    .frame_count_i (fcnt_q),
    .x_res_i       (x_res_q),
    .y_res_i       (y_res_q),
    .cnt_res_i     (cnt_res_q),
    .start_c       (start_c),
    .stop_c        (stop_c),
    .continuous_o  (continuous),
    .rgb_cmp_o     (sh_rgb),
    .compare_o     (sh_cmp),
    .less_than_o   (sh_lt),
    .range_o       (sh_range),
    .done_o        (done)
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
    ,
    .ie_o          (ie)
`endif
  );

  // Frame sequencer, drain counter, active config latch and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      stop_pend_q <= 1'b0;
      clear_q     <= 1'b0;
      act_rgb_q   <= '0;
      act_cmp_q   <= '0;
      act_lt_q    <= '0;
      act_range_q <= '0;
      x_res_q     <= '0;
      y_res_q     <= '0;
      cnt_res_q   <= '0;
      fcnt_q      <= '0;
    end else begin
      clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_c) state_q <= ST_ARM;
        end
        ST_ARM: begin
          if (stop_c) begin
            state_q <= ST_IDLE;
          end else if (sop_c) begin
            act_rgb_q   <= sh_rgb;
            act_cmp_q   <= sh_cmp;
            act_lt_q    <= sh_lt;
            act_range_q <= sh_range;
            if (eop_c) begin
              state_q <= ST_DRAIN;
              drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // A new SOP before EOP aborts the frame without capturing
          if (sop_c) begin
            state_q <= ST_CLEAR;
            clear_q <= 1'b1;
          end else if (eop_c) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_W'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_CAPTURE;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        ST_CAPTURE: begin
          x_res_q   <= X_clusters;
          y_res_q   <= Y_clusters;
          cnt_res_q <= cluster_counters;
          fcnt_q    <= fcnt_q + FCNT_W'(1);
          state_q   <= ST_CLEAR;
          clear_q   <= 1'b1;
        end
        ST_CLEAR: begin
          if (continuous && !stop_pend_q && !stop_c) begin
            state_q <= ST_ARM;
          end else begin
            state_q <= ST_IDLE;
          end
          stop_pend_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
      // STOP during an active frame lets it finish, then returns to IDLE
      if (stop_c && ((state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                     (state_q == ST_CAPTURE))) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  // SOP pixel is admitted in the same cycle the ARM->RUN edge happens
  assign stream_enable = (state_q == ST_RUN) | ((state_q == ST_ARM) & sop_c);
  assign cluster_clear = clear_q;
  assign rgb_cmp       = act_rgb_q;
  assign compare       = act_cmp_q;
  assign less_than     = act_lt_q;
  assign range         = act_range_q;
`ifdef PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN
  assign irq           = done & ie;
`endif

endmodule

// File: doc/pixel_cluster_frame_ctrl.md
Name: pixel_cluster_frame_ctrl

Overview:
- Per-frame sequencer and Avalon-MM register front end for the pixel-cluster datapath (ST frame tracker -> color filter -> x/y clusterer).
- Holds shadow thresholds and latches them into active config at start of frame; gates the datapath to whole frames only.
- After each frame: waits out clusterer latency, snapshots cluster results into readable registers, then pulses a clusterer clear.

Parameters:
- N_CLUSTERS, 4, cluster slots in the clusterer
- X_Y_BITS, 16, coordinate/range width
- COUNTER_BITS, 16, per-cluster pixel count width
- COLOR_BITS, 8, bits per color channel
- N_COLORS, 3, channels; r = top slice, b = slice 0
- DRAIN_CYCLES, 8, cycles from EOP beat to capture; covers filter + clusterer pipeline; must be >= 1

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  5  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered, valid 1 cycle after avs_read
- st_valid, st_ready, st_startofpacket, st_endofpacket  in  1 each  snooped video ST handshake
- rgb_cmp  out  N_COLORS*COLOR_BITS  active thresholds to filter
- compare  out  N_COLORS  active compare enables
- less_than  out  N_COLORS  active compare directions
- range  out  X_Y_BITS  active cluster range
- stream_enable  out  1  qualifies pixel_valid into filter/clusterer
- cluster_clear  out  1  one-cycle synchronous clear to clusterer
- X_clusters, Y_clusters  in  N_CLUSTERS*X_Y_BITS  live clusterer centroids
- cluster_counters  in  N_CLUSTERS*COUNTER_BITS  live clusterer counts

Behaviour:
- Beat = st_valid & st_ready; sop = beat & st_startofpacket; eop = beat & st_endofpacket.
- Reset: state IDLE; all outputs 0; shadow/active config 0; result regs 0; frame_count 0; sticky bits 0.
- Register map (write/read):
  - 0 CTRL: b0 START (W1, self-clearing), b1 CONTINUOUS (RW), b2 STOP (W1, self-clearing).
  - 1 STATUS: b0 busy (RO, state != IDLE), b1 done (sticky, W1C), b2 frame_err (sticky, W1C), [31:16] frame_count (RO, wraps at 0xFFFF).
  - 2 RGB_CMP[23:0]; 3 {LESS_THAN[6:4], COMPARE[2:0]}; 4 RANGE[15:0]. All shadow, RW.
  - 8+i: {Y_res[i], X_res[i]}; 16+i: count_res[i], i < N_CLUSTERS. RO.
  - Unmapped reads return 0.
- FSM:
  - IDLE -> ARM on START.
  - ARM -> RUN on sop; active config <= shadow in the same edge.
  - RUN -> DRAIN on eop. A sop in RUN with no prior eop sets frame_err and goes to CLEAR; no capture.
  - DRAIN counts DRAIN_CYCLES, then -> CAPTURE.
  - CAPTURE (1 cycle): result regs <= live inputs; done <= 1; frame_count++.
  - CLEAR (1 cycle): cluster_clear = 1. Then -> ARM if CONTINUOUS & no stop pending, else IDLE.
  - An sop+eop single-beat frame goes ARM -> DRAIN directly.
- stream_enable = (state==RUN) | (state==ARM & sop), combinational, so the SOP pixel is counted.
- START while busy is ignored. STOP in ARM -> IDLE next cycle. STOP in RUN/DRAIN sets stop_pending; the frame completes, then CLEAR -> IDLE.
- Shadow writes at any time never alter active config mid-frame.
- Simultaneous W1C of done and CAPTURE setting done: set wins.
- reset_n low mid-frame: immediate return to reset values.

Optional Feature:
- PIXEL_CLUSTER_FRAME_CTRL_IRQ_EN defined: adds output irq (1 bit), irq = done & ie, with ie at CTRL b3 (RW, reset 0).
- Undefined: no irq port; CTRL b3 reads 0 and writes are ignored.

Decomposition:
- Package pixel_cluster_pkg holds:
  - FSM state enum typedef
  - register address localparams (CTRL, STATUS, RGB_CMP, CMP_CFG, RANGE, XY_BASE=8, CNT_BASE=16)
  - CTRL/STATUS bit-index constants
- Sub-module pixel_cluster_frame_ctrl_regs: Avalon-MM decode, shadow and sticky registers, readback mux.
- FSM, drain counter and capture stay in the top.

Test Plan:
- Reset: after reset_n release, read STATUS -> 0; rgb_cmp, range, stream_enable, cluster_clear all 0.
- Single frame: write RGB_CMP=0x102030, RANGE=50, START; 4-beat frame (sop on beat 0, eop on beat 3). Expect rgb_cmp=0x102030 from the sop edge; stream_enable high for exactly 4 beat cycles; capture at eop+DRAIN_CYCLES; one cluster_clear pulse; STATUS=0x00010002.
- Shadow isolation: write RANGE=99 mid-frame -> range stays 50 until next sop, then 99.
- Capture: drive live X_clusters slot0=93, Y=106, count=3 before capture, change them after. Read addr 8 -> 0x006A005D; addr 16 -> 3.
- Error/abort: second sop before eop -> frame_err=1, no frame_count increment, cluster_clear pulses, state ARM (CONTINUOUS=1).
- STOP in RUN: frame completes, capture happens, then busy=0. START while busy: no effect.
